// File: rtl/inst_sequencer.sv
// Instruction sequencer for a systolic PE core: walks weight load, activation load,
// execute, drain and write-back phases, emitting one registered 35-bit instruction per cycle.
module inst_sequencer #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               acc_en,
  input  logic [addr_bw-1:0] n_act,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               busy,
  output logic               done
);

  // state     | meaning
  // s_idle    | waiting for start, idle word on inst
  // s_wld_mem | read col weight vectors from xmem into L0 (one extra cycle for read latency)
  // s_wld_pe  | WS only: shift weights from L0 into PEs, then let them settle for row cycles
  // s_act_mem | read n_act activation vectors from xmem into L0
  // s_exec    | stream activations through the array
  // s_drain   | wait for the core to report drained results
  // s_wb      | pop ofifo and write psums to psum memory (one cycle behind the pop)
  // s_done    | one-cycle completion pulse
  typedef enum logic [2:0] {
    s_idle, s_wld_mem, s_wld_pe, s_act_mem, s_exec, s_drain, s_wb, s_done
  } state_t;

  localparam int          cw        = addr_bw + 1;
  localparam logic [34:0] idle_word = 35'h1_800C_0000;
  localparam logic [cw-1:0] col_c   = cw'(col);
  localparam logic [cw-1:0] pe_last = cw'(row + col - 1);

  state_t             state, state_n;
  logic [cw-1:0]      cnt, cnt_n;
  logic               mode_q, acc_q, mode_n, acc_n;
  logic [addr_bw-1:0] n_q, w_q, x_q, p_q;
  logic [addr_bw-1:0] n_n, w_n, x_n, p_n;
  logic               accept;
  logic [cw-1:0]      n_ext;

  function automatic logic [34:0] encode(
    input state_t             s,
    input logic [cw-1:0]      k,
    input logic               m,
    input logic               acc,
    input logic [addr_bw-1:0] n,
    input logic [addr_bw-1:0] wb,
    input logic [addr_bw-1:0] xb,
    input logic [addr_bw-1:0] pb
  );
    logic [34:0]   w;
    logic [cw-1:0] nk;
    w  = idle_word;
    nk = {1'b0, n};
    if (s != s_idle) w[33] = m;
    case (s)
      s_wld_mem: begin
        if (k < col_c) begin
          w[19]   = 1'b0;
          w[17:7] = 11'(wb + k[addr_bw-1:0]);
        end
        if (k != '0) begin
          w[2] = 1'b1;
          w[5] = m;
        end
      end
      s_wld_pe: begin
        if (k < col_c) begin
          w[3] = 1'b1;
          w[0] = 1'b1;
        end
      end
      s_act_mem: begin
        if (k < nk) begin
          w[19]   = 1'b0;
          w[17:7] = 11'(xb + k[addr_bw-1:0]);
        end
        if (k != '0) w[2] = 1'b1;
      end
      s_exec: begin
        w[3] = 1'b1;
        w[1] = 1'b1;
        w[4] = m;
      end
      s_wb: begin
        if (k < nk) w[6] = 1'b1;
        if (k != '0) begin
          w[34]    = acc;
          w[32]    = 1'b0;
          w[31]    = 1'b0;
          w[30:20] = 11'(pb + k[addr_bw-1:0] - 1'b1);
        end
      end
      default: ;
    endcase
    return w;
  endfunction

  always_comb begin
    accept  = (state == s_idle) && start;
    mode_n  = accept ? mode   : mode_q;
    acc_n   = accept ? acc_en : acc_q;
    n_n     = accept ? n_act  : n_q;
    w_n     = accept ? w_base : w_q;
    x_n     = accept ? x_base : x_q;
    p_n     = accept ? p_base : p_q;
    n_ext   = {1'b0, n_q};
    state_n = state;
    cnt_n   = cnt + 1'b1;
    case (state)
      s_idle: begin
        cnt_n = '0;
        if (start) state_n = (n_act == '0) ? s_done : s_wld_mem;
      end
      s_wld_mem: begin
        if (cnt == col_c) begin
          cnt_n   = '0;
          state_n = mode_q ? s_act_mem : s_wld_pe;
        end
      end
      s_wld_pe: begin
        if (cnt == pe_last) begin
          cnt_n   = '0;
          state_n = s_act_mem;
        end
      end
      s_act_mem: begin
        if (cnt == n_ext) begin
          cnt_n   = '0;
          state_n = s_exec;
        end
      end
      s_exec: begin
        if (cnt + 1'b1 == n_ext) begin
          cnt_n   = '0;
          state_n = s_drain;
        end
      end
      s_drain: begin
        cnt_n = '0;
        if (ofifo_valid) state_n = s_wb;
      end
      s_wb: begin
        if (cnt == n_ext) begin
          cnt_n   = '0;
          state_n = s_done;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = s_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= s_idle;
      cnt    <= '0;
      mode_q <= 1'b0;
      acc_q  <= 1'b0;
      n_q    <= '0;
      w_q    <= '0;
      x_q    <= '0;
      p_q    <= '0;
      inst   <= idle_word;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_q <= mode_n;
      acc_q  <= acc_n;
      n_q    <= n_n;
      w_q    <= w_n;
      x_q    <= x_n;
      p_q    <= p_n;
      // Outputs are encoded from the next state so inst lines up with the state it describes.
      inst   <= encode(state_n, cnt_n, mode_n, acc_n, n_n, w_n, x_n, p_n);
      busy   <= (state_n != s_idle);
      done   <= (state_n == s_done);
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: directed vector table, hand sequences for reset abort,
// and randomized operations checked cycle by cycle against a phase-list model.
module tb_inst_sequencer;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int MOD = 1 << AW;
  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  logic          clk = 1'b0;
  logic          reset, start, mode, acc_en, ofifo_valid;
  logic [AW-1:0] n_act, w_base, x_base, p_base;
  logic [34:0]   inst;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [34:0] w;
    bit          b;
    bit          d;
  } exp_t;
  exp_t exp_q[$];
  int   drain_start;

  always #5 clk = ~clk;

  inst_sequencer #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .acc_en(acc_en),
    .n_act(n_act), .w_base(w_base), .x_base(x_base), .p_base(p_base),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  function automatic logic [34:0] mk(bit acc, bit m, bit pcen, bit pwen, int paddr,
                                     bit xcen, bit xwen, int xaddr, logic [6:0] f);
    logic [10:0] pa, xa;
    pa = 11'(paddr % MOD);
    xa = 11'(xaddr % MOD);
    return {acc, m, pcen, pwen, pa, xcen, xwen, xa, f};
  endfunction

  function automatic void push(logic [34:0] w, bit b, bit d);
    exp_t e;
    e.w = w; e.b = b; e.d = d;
    exp_q.push_back(e);
  endfunction

  // Expected per-cycle outputs, cycle 1 after the start cycle first, ending with one idle cycle.
  function automatic void build(bit m, bit acc, int n, int w, int x, int p, int d);
    exp_q.delete();
    drain_start = 1 << 30;
    if (n == 0) begin
      push(mk(0, m, 1, 1, 0, 1, 1, 0, 7'b0), 1, 1);
      push(IDLE_W, 0, 0);
      return;
    end
    for (int k = 0; k <= COL; k++)
      push(mk(0, m, 1, 1, 0, !(k < COL), 1, (k < COL) ? w + k : 0,
              {1'b0, m && k > 0, 1'b0, 1'b0, k > 0, 1'b0, 1'b0}), 1, 0);
    if (!m)
      for (int k = 0; k < ROW + COL; k++)
        push(mk(0, m, 1, 1, 0, 1, 1, 0, {3'b0, k < COL, 2'b0, k < COL}), 1, 0);
    for (int k = 0; k <= n; k++)
      push(mk(0, m, 1, 1, 0, !(k < n), 1, (k < n) ? x + k : 0,
              {4'b0, k > 0, 2'b0}), 1, 0);
    for (int k = 0; k < n; k++)
      push(mk(0, m, 1, 1, 0, 1, 1, 0, {2'b0, m, 1'b1, 1'b0, 1'b1, 1'b0}), 1, 0);
    drain_start = exp_q.size() + 1;
    for (int j = 0; j <= d; j++)
      push(mk(0, m, 1, 1, 0, 1, 1, 0, 7'b0), 1, 0);
    for (int k = 0; k <= n; k++)
      push(mk(acc && k > 0, m, !(k > 0), !(k > 0), (k > 0) ? p + k - 1 : 0, 1, 1, 0,
              {k < n, 6'b0}), 1, 0);
    push(mk(0, m, 1, 1, 0, 1, 1, 0, 7'b0), 1, 1);
    push(IDLE_W, 0, 0);
  endfunction

  task automatic chk_out(string name, int c, logic [34:0] ew, bit eb, bit ed);
    checks++;
    if (inst !== ew || busy !== eb || done !== ed) begin
      errors++;
      $display("FAIL %s cycle %0d: got inst=%09h busy=%b done=%b want inst=%09h busy=%b done=%b",
               name, c, inst, busy, done, ew, eb, ed);
    end
  endtask

  task automatic chk_int(string name, int act, int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // rs: 0 = no second start, -1 = random cycle, >0 = that cycle. stop_at > 0 ends early.
  task automatic run_op(input bit m, input bit acc, input int n, input int w, input int x,
                        input int p, input int d, input int rs, input int stop_at,
                        output int done_cyc, output int nl, output int niw, output int nir,
                        output int nex, output int nxc, output int ndn);
    int len, rsc;
    build(m, acc, n, w, x, p, d);
    len = exp_q.size();
    rsc = rs;
    if (rs < 0) rsc = (len > 4) ? int'($urandom_range(2, len - 2)) : 0;
    if (stop_at > 0 && stop_at < len) len = stop_at;
    done_cyc = -1; nl = 0; niw = 0; nir = 0; nex = 0; nxc = 0; ndn = 0;
    @(negedge clk);
    start = 1; mode = m; acc_en = acc;
    n_act = AW'(n); w_base = AW'(w); x_base = AW'(x); p_base = AW'(p);
    ofifo_valid = 1'($urandom);
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      start  = (rsc > 0 && c == rsc);
      mode   = 1'($urandom); acc_en = 1'($urandom);
      n_act  = AW'($urandom); w_base = AW'($urandom);
      x_base = AW'($urandom); p_base = AW'($urandom);
      chk_out("seq", c, exp_q[c-1].w, exp_q[c-1].b, exp_q[c-1].d);
      nl += int'(inst[0]); niw += int'(inst[5]); nir += int'(inst[4]);
      nex += int'(inst[1]); nxc += int'(!inst[19]); ndn += int'(done);
      if (done && done_cyc < 0) done_cyc = c;
      if (c >= drain_start && c < drain_start + d) ofifo_valid = 1'b0;
      else if (c == drain_start + d)               ofifo_valid = 1'b1;
      else                                         ofifo_valid = 1'($urandom);
    end
    start = 0;
  endtask

  typedef struct {
    bit m; bit acc; int n; int w; int x; int p; int d; int rs;
    int e_done; int e_load; int e_iwr; int e_ird; int e_exec; int e_xcen;
  } vec_t;

  initial begin
    vec_t vt[6];
    int dc, nl, niw, nir, nex, nxc, ndn;
    vt[0] = '{0, 1, 4,    0,   16,  32, 0,  0, 41, 8, 0, 0, 4, 12};
    vt[1] = '{1, 0, 2,  100,  200, 300, 0,  0, 19, 0, 8, 2, 2, 10};
    vt[2] = '{0, 0, 3,   40, 2046, 500, 0,  0, 38, 8, 0, 0, 3, 11};
    vt[3] = '{0, 1, 0,   10,   20,  30, 0,  0,  1, 0, 0, 0, 0,  0};
    vt[4] = '{0, 1, 1,    5,    6,   7, 20, 0, 52, 8, 0, 0, 1,  9};
    vt[5] = '{0, 0, 2, 2040,   64, 2047, 0, 5, 35, 8, 0, 0, 2, 10};

    reset = 0; start = 0; mode = 0; acc_en = 0; ofifo_valid = 0;
    n_act = '0; w_base = '0; x_base = '0; p_base = '0;
    repeat (3) @(negedge clk);
    chk_out("reset_state", 0, IDLE_W, 0, 0);
    reset = 1;

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].m, vt[i].acc, vt[i].n, vt[i].w, vt[i].x, vt[i].p, vt[i].d, vt[i].rs, 0,
             dc, nl, niw, nir, nex, nxc, ndn);
      chk_int($sformatf("vec%0d done_cycle", i), dc, vt[i].e_done);
      chk_int($sformatf("vec%0d load_cycles", i), nl, vt[i].e_load);
      chk_int($sformatf("vec%0d ififo_wr_cycles", i), niw, vt[i].e_iwr);
      chk_int($sformatf("vec%0d ififo_rd_cycles", i), nir, vt[i].e_ird);
      chk_int($sformatf("vec%0d exec_cycles", i), nex, vt[i].e_exec);
      chk_int($sformatf("vec%0d xmem_reads", i), nxc, vt[i].e_xcen);
      chk_int($sformatf("vec%0d done_pulses", i), ndn, 1);
    end

    // Abort in EXEC: cycle 32 of a WS n_act=4 run is the second execute cycle.
    run_op(0, 0, 4, 0, 16, 32, 0, 0, 32, dc, nl, niw, nir, nex, nxc, ndn);
    chk_int("abort exec_seen", nex, 2);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("abort_in_reset", i, IDLE_W, 0, 0);
    end
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out("abort_after_reset", i, IDLE_W, 0, 0);
    end

    for (int t = 0; t < 30; t++) begin
      bit rm, ra;
      int rn;
      rm = 1'($urandom); ra = 1'($urandom);
      rn = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
      run_op(rm, ra, rn, int'($urandom_range(0, MOD - 1)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(MOD - 4, MOD - 1))
                                         : int'($urandom_range(0, MOD - 1)),
             int'($urandom_range(MOD - 12, MOD - 1)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ? -1 : 0, 0,
             dc, nl, niw, nir, nex, nxc, ndn);
      chk_int($sformatf("rand%0d done_pulses", t), ndn, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter row, default 8, PE array rows.
REQ-002 Parameter col, default 8, PE array columns and weight vectors per kernel load.
REQ-003 Parameter addr_bw, default 11, SRAM address width (2048 words).
REQ-004 Port clk, input, 1, sole clock; all logic SHALL be rising-edge triggered.
REQ-005 Port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-006 Port start, input, 1, one-cycle request that begins an operation.
REQ-007 Port mode, input, 1, 0 = weight-stationary (WS), 1 = output-stationary (OS); captured at accepted start.
REQ-008 Port acc_en, input, 1, accumulate flag copied to inst[34] during the WB state; captured at start.
REQ-009 Port n_act, input, addr_bw, number of activation vectors; captured at start.
REQ-010 Port w_base / x_base / p_base, input, addr_bw each, weight, activation and psum base addresses; captured at start.
REQ-011 Port ofifo_valid, input, 1, core valid output indicating drained results are ready.
REQ-012 Port inst, output, 35, instruction word driven to core.
REQ-013 Port busy, output, 1, high in every non-IDLE state.
REQ-014 Port done, output, 1, one-cycle completion pulse.

Function
REQ-015 inst field map SHALL be: [34] acc, [33] mode, [32] psum CEN, [31] psum WEN, [30:20] psum addr, [19] xmem CEN, [18] xmem WEN, [17:7] xmem addr, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-016 IDLE word SHALL be 35'h1_800C_0000: both CEN and WEN high, all other bits 0. Every bit not listed for a state SHALL hold its IDLE value.
REQ-017 inst and done SHALL be registered outputs; all fields change only on the clk rising edge.
REQ-018 inst[33] SHALL equal the captured mode in every non-IDLE state.
REQ-019 States and order: IDLE, WLD_MEM, WLD_PE, ACT_MEM, EXEC, DRAIN, WB, DONE. OS mode SHALL skip WLD_PE.
REQ-020 In IDLE, start=1 SHALL capture all inputs and move to WLD_MEM. start in any other state SHALL be ignored.
REQ-021 start with n_act=0 SHALL go IDLE -> DONE directly, emitting no memory access.
REQ-022 WLD_MEM SHALL last col+1 cycles.
- cycle k < col: xmem CEN=0, WEN=1, addr = w_base+k.
- cycles 1..col: l0_wr=1 (one-cycle SRAM read latency).
- OS mode: ififo_wr mirrors l0_wr.
REQ-023 WLD_PE (WS only) SHALL last row+col cycles.
- first col cycles: l0_rd=1, load=1.
- remaining row cycles: idle word, to let weights settle.
REQ-024 ACT_MEM SHALL last n_act+1 cycles with the same read/l0_wr pattern as WLD_MEM, using addr = x_base+k for k < n_act.
REQ-025 EXEC SHALL last n_act cycles with l0_rd=1 and execute=1; OS mode also asserts ififo_rd=1.
REQ-026 DRAIN SHALL hold the idle word (plus mode) until ofifo_valid=1, then enter WB on the next edge; there is no timeout.
REQ-027 WB SHALL last n_act+1 cycles.
- cycles 0..n_act-1: ofifo_rd=1.
- cycles 1..n_act: psum CEN=0, WEN=0, addr = p_base+(k-1), inst[34]=acc_en.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 Address sums SHALL wrap modulo 2^addr_bw (2047+1 -> 0).
REQ-030 Internal counters SHALL be addr_bw+1 bits wide so that n_act=2047 plus the +1 cycle does not overflow.

Reset
REQ-031 While reset=0 at a clk edge, the block SHALL enter IDLE, inst SHALL be 35'h1_800C_0000, and busy=0, done=0, counters=0.
REQ-032 Reset asserted mid-operation SHALL abort with no further memory enables; the captured operands are discarded.

Verification
REQ-033 Reset: hold reset=0 for 3 cycles in EXEC -> next cycle inst=35'h1_800C_0000, busy=0.
REQ-034 WS, n_act=4, w_base=0, x_base=16, p_base=32, ofifo_valid tied 1.
- xmem addrs 0..7 then 16..19.
- 8 load cycles, then 8 idle cycles.
- 4 execute cycles.
- psum writes to 32..35 with WEN=0.
- done pulse at cycle 1+9+16+5+4+1+5 = 41 after start.
REQ-035 OS, n_act=2 -> no load=1 cycle ever; ififo_wr high in 8 cycles, ififo_rd high in 2 cycles; inst[33]=1 throughout busy.
REQ-036 Wrap: x_base=2046, n_act=3 -> xmem addrs 2046, 2047, 0.
REQ-037 Edge cases:
- start with n_act=0 -> done on the 2nd cycle, CEN never low.
- second start during busy -> ignored, single done pulse.
- ofifo_valid held 0 for 20 cycles -> FSM stays in DRAIN, then enters WB one cycle after ofifo_valid rises.
